// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned LAT_W = 4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_latency_timer.sv
// Loadable down-counter that times the BUSY wait; zero flags the last wait cycle.
module mem_latency_timer
  import data_mem_responder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_value,
  input  logic             en,
  output logic             zero
);

  logic [LAT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data-memory responder: one access at a time, fixed wait latency,
// single-cycle response pulse and a pipeline stall while the access is in flight.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              stall,
  output logic              err_oob,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int unsigned      LOAD_INT = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam logic [LAT_W-1:0] LOAD_VAL = LAT_W'(LOAD_INT);

  // Store data is committed on the accepting edge, so only the fields needed
  // later (direction, range and index) are captured.
  typedef struct packed {
    logic              we;
    logic              oob;
    logic [ADDR_W-1:0] idx;
  } req_t;

  logic [31:0] mem [DEPTH];

  state_t             state, next_state;
  req_t               cap;
  logic               accept;
  logic               req_oob;
  logic               timer_zero;
  logic [ADDR_W-1:0]  rd_idx;
  logic               rd_hit;
  logic [31:0]        resp_rdata_q;
  logic               err_oob_q;
  logic [CNT_W-1:0]   rd_count_q;
  logic [CNT_W-1:0]   wr_count_q;

  assign accept  = (state == IDLE) && req_valid;
  assign req_oob = (req_addr[31:ADDR_W] != '0);

  mem_latency_timer u_timer (
    .clk        (clk),
    .rst        (reset),
    .load       (accept && (LATENCY > 0)),
    .load_value (LOAD_VAL),
    .en         (state == BUSY),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (req_valid) next_state = (LATENCY > 0) ? BUSY : RESP;
      BUSY:    if (timer_zero) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    stall      = (state == BUSY) || ((state == IDLE) && req_valid);
  end

  // The read happens in the cycle before RESP: with zero latency that is the
  // accepting IDLE cycle, so the live request is used instead of the capture.
  always_comb begin
    rd_idx = cap.idx;
    rd_hit = !cap.we && !cap.oob;
    if (state == IDLE) begin
      rd_idx = req_addr[ADDR_W-1:0];
      rd_hit = !req_we && !req_oob;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !reset && req_we && !req_oob) begin
      mem[req_addr[ADDR_W-1:0]] <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap          <= '0;
      resp_rdata_q <= '0;
      err_oob_q    <= 1'b0;
      rd_count_q   <= '0;
      wr_count_q   <= '0;
    end else begin
      if (accept) begin
        cap.we  <= req_we;
        cap.oob <= req_oob;
        cap.idx <= req_addr[ADDR_W-1:0];
        if (req_oob) err_oob_q <= 1'b1;
      end
      resp_rdata_q <= ((next_state == RESP) && rd_hit) ? mem[rd_idx] : '0;
      if (state == RESP) begin
        if (cap.we) wr_count_q <= sat_inc(wr_count_q);
        else        rd_count_q <= sat_inc(rd_count_q);
      end
    end
  end

  assign resp_rdata = resp_rdata_q;
  assign err_oob    = err_oob_q;
  assign rd_count   = rd_count_q;
  assign wr_count   = wr_count_q;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the processor's MEM-stage data-memory interface: accepts one load or store request at a time and holds it for a programmable wait latency.
- Returns read data, or a write acknowledge, with a one-cycle resp_valid pulse.
- Drives a stall back to the pipeline so MEM and earlier stages freeze until the access completes.
- Word-addressed, 32-bit data, matching the processor's PC+1 word addressing.

Parameters:
DEPTH, 256, number of 32-bit words in the storage array (power of two)
ADDR_W, 8, index width; must equal log2(DEPTH)
LATENCY, 2, wait cycles inserted between acceptance and response (0..15)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  MEM stage presents an access; held stable until resp_valid is seen
req_we  input  1  1 = store, 0 = load
req_addr  input  32  word address (the ALU result)
req_wdata  input  32  store data
req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready
resp_valid  output  1  one-cycle pulse marking completion of the accepted access
resp_rdata  output  32  load data, valid with resp_valid; 0 for stores
stall  output  1  combinational freeze request to the pipeline
err_oob  output  1  sticky out-of-range flag
rd_count  output  16  saturating count of completed loads
wr_count  output  16  saturating count of completed stores

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - resp_valid, resp_rdata, err_oob, rd_count, wr_count = 0.
  - Captured request registers are cleared.
  - The storage array is not reset and keeps its contents.
- States IDLE, BUSY, RESP. Transitions:
  - IDLE and req_valid: accept. Go to BUSY with wait counter = LATENCY-1 if LATENCY > 0, else go straight to RESP.
  - BUSY: decrement the counter each cycle. Go to RESP on the cycle the counter reads 0.
  - RESP: always return to IDLE next cycle.
- Latency: resp_valid is high exactly LATENCY+1 cycles after the accepting edge. Each access occupies a minimum of 2 cycles.
- Capture at acceptance: req_addr, req_we and req_wdata are registered on the accepting edge. Inputs are ignored after that.
- Store: the array write commits on the accepting edge. resp_valid then serves as the acknowledge.
- Load: the array is read in the cycle before RESP and registered. resp_rdata holds that value during RESP and is 0 at all other times.
- Outputs per state:
  - req_ready = (state == IDLE).
  - resp_valid = (state == RESP).
  - stall = (state == BUSY) || (state == IDLE && req_valid).
  - In RESP, stall = 0, so the pipeline advances on that edge. The request still present on req_valid in RESP is the same one and is not re-accepted, because req_ready = 0.
- Out of range: captured addr[31:ADDR_W] != 0.
  - The store is dropped, or the load returns 0.
  - The response is still produced with normal timing.
  - err_oob sets and remains set until reset.
- Counters: rd_count / wr_count increment in the RESP cycle. Out-of-range accesses are counted. Both saturate at 16'hFFFF.
- Reset mid-access: the in-flight response is discarded and no resp_valid is produced. A store accepted before reset stays committed.
- Simultaneous req_valid in RESP or BUSY is never accepted. The next acceptance is possible in the IDLE cycle after RESP.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, BUSY=2'd1, RESP=2'd2), the counter width of 16, and the latency counter width of 4.
- One sub-module, mem_latency_timer: a loadable 4-bit down-counter with load, enable and zero outputs, instantiated once for the BUSY wait.

Test Plan:
- Reset then store: store 32'hDEADBEEF to addr 5 with LATENCY=2 → stall high for 3 cycles, resp_valid on the 3rd edge after acceptance, resp_rdata=0, wr_count=1, err_oob=0.
- Load after store: load addr 5 → resp_valid 3 cycles after acceptance with resp_rdata=32'hDEADBEEF, rd_count=1; resp_rdata returns to 0 the following cycle.
- LATENCY=0 back-to-back: two loads, addr 1 then addr 2, with req_valid held → each completes in 2 cycles (accept, RESP), req_ready low during RESP, no duplicate acceptance, rd_count=2.
- Out of range: store to addr 300 with DEPTH=256, then load addr 300 mod 256 = 44 → err_oob=1 and stays set; word 44 is unchanged (still its prior value); both responses arrive on time.
- Reset in BUSY: accept store 32'h12345678 to addr 9, assert reset one cycle later → no resp_valid, all outputs 0; a subsequent load of addr 9 returns 32'h12345678.
- Counter saturation: force 65536 loads (or preload via a backdoor) → rd_count holds at 16'hFFFF.
